ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 94 +++++++++
 tb/tb_ps2_host_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter driving open-collector line enables
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);
  localparam int IW = INHIBIT_CYCLES > 1 ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RELEASE, SHIFT, ACK, WAIT_IDLE, ERR} state_t;

  state_t state, state_d;
  logic [1:0] clk_s, data_s;
  logic [FILTER_LEN-2:0] hist;
  logic [FILTER_LEN-1:0] win;
  logic filt, filt_q, fall;
  logic [9:0] frame;
  logic [3:0] idx;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic data_q, inh_last, timed, timeout;

  // the current synchronized sample plus FILTER_LEN-1 history samples must all agree
  assign win = {hist, clk_s[1]};
  assign fall = filt_q & ~filt;
  assign inh_last = state == INHIBIT && inh_cnt == INH_LAST;
  assign timed = state inside {RELEASE, SHIFT, ACK, WAIT_IDLE};
  assign timeout = timed && to_cnt == TO_LAST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      clk_s <= '1;
      data_s <= '1;
      hist <= '1;
      filt <= 1'b1;
      filt_q <= 1'b1;
      frame <= '0;
      idx <= '0;
      inh_cnt <= '0;
      to_cnt <= '0;
      data_q <= 1'b0;
    end else begin
      state <= state_d;
      clk_s <= {clk_s[0], ps2_clk_i};
      data_s <= {data_s[0], ps2_data_i};
      hist <= win[FILTER_LEN-2:0];
      filt <= &win ? 1'b1 : ~|win ? 1'b0 : filt;
      filt_q <= filt;
      inh_cnt <= state == INHIBIT ? (inh_cnt == INH_LAST ? inh_cnt : inh_cnt + 1'b1) : '0;
      to_cnt <= timed ? (to_cnt == TO_LAST ? to_cnt : to_cnt + 1'b1) : '0;
      if (state == IDLE && tx_valid) frame <= {1'b1, ~^tx_data, tx_data};
      idx <= state == SHIFT ? idx + 4'(fall) : '0;
      data_q <= inh_last ? 1'b1 : state == SHIFT && fall ? ~frame[idx] : timed ? data_q : 1'b0;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = tx_valid ? INHIBIT : IDLE;
      INHIBIT:   state_d = inh_cnt == INH_LAST ? RELEASE : INHIBIT;
      RELEASE:   state_d = SHIFT;
      SHIFT:     state_d = fall && idx == 4'd9 ? ACK : SHIFT;
      ACK:       state_d = fall ? (data_s[1] ? ERR : WAIT_IDLE) : ACK;
      WAIT_IDLE: state_d = filt && data_s[1] ? IDLE : WAIT_IDLE;
      default:   state_d = IDLE;
    endcase
    if (timeout) state_d = ERR;
  end

  // data enable leads the clock release by one cycle so the start bit is set up first
  assign ps2_data_oe = inh_last | (data_q & (state == RELEASE || state == SHIFT));
  assign ps2_clk_oe = state == INHIBIT;
  assign tx_ready = state == IDLE;
  assign busy = ~tx_ready;
  assign tx_done = state == WAIT_IDLE && filt && data_s[1] && !timeout;
  assign tx_error = state == ERR;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model with scoreboard queues for frames and per-byte outcomes
module tb_ps2_host_tx;
  localparam int INH = 1000;
  localparam int TO = 5000;
  localparam int HP = 40;

  logic clk, rst, tx_valid, tx_ready, ps2_clk_i, ps2_data_i;
  logic ps2_clk_oe, ps2_data_oe, tx_done, tx_error, busy;
  logic [7:0] tx_data;
  logic dev_clk, dev_dat, glt, after_pulse;
  logic [7:0] fq[$];
  logic rq[$];
  int n_chk, n_pass;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .tx_done(tx_done), .tx_error(tx_error), .busy(busy)
  );

  assign ps2_clk_i = ~(ps2_clk_oe | dev_clk | glt);
  assign ps2_data_i = ~(ps2_data_oe | dev_dat);

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 20000) begin @(negedge clk); n++; end
    check("ready_wait", tx_ready, 1);
  endtask

  // res: 1 = tx_done expected, 0 = tx_error expected, -1 = no outcome
  task automatic send(input logic [7:0] d, input logic push_frame, input int res);
    wait_ready();
    @(negedge clk);
    tx_data = d;
    tx_valid = 1;
    if (push_frame) fq.push_back(d);
    if (res >= 0) rq.push_back(res[0]);
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic wait_req(output int inh, output logic early);
    int n = 0;
    inh = 0;
    early = 0;
    while (!ps2_clk_oe && n < 3000) begin @(negedge clk); n++; end
    while (ps2_clk_oe && inh < 3000) begin early = ps2_data_oe; inh++; @(negedge clk); end
  endtask

  task automatic dev_rx(input logic ack, input logic glitch, output logic [10:0] f);
    int inh;
    logic early;
    logic [7:0] d;
    wait_req(inh, early);
    check("inhibit_len", inh, INH);
    check("data_before_clk_release", early, 1);
    repeat (HP) @(negedge clk);
    f[0] = ps2_data_i;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1;
      repeat (HP) @(negedge clk);
      f[i] = ps2_data_i;
      dev_clk = 0;
      repeat (HP / 2) @(negedge clk);
      glt = glitch && i == 3;
      @(negedge clk);
      glt = 0;
      repeat (HP / 2 - 1) @(negedge clk);
    end
    dev_dat = ack;
    repeat (HP / 2) @(negedge clk);
    dev_clk = 1;
    repeat (HP) @(negedge clk);
    dev_clk = 0;
    repeat (HP / 2) @(negedge clk);
    dev_dat = 0;
    check("frame_queued", fq.size() != 0, 1);
    if (fq.size() != 0) begin
      d = fq.pop_front();
      check("frame", f, {1'b1, ~^d, d, 1'b0});
    end
  endtask

  always @(negedge clk) begin
    if (after_pulse) begin
      check("ready_after_pulse", tx_ready, 1);
      check("single_cycle_pulse", {tx_done, tx_error}, 0);
      check("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
    end
    after_pulse <= tx_done | tx_error;
    if (tx_done | tx_error) begin
      check("not_both", tx_done & tx_error, 0);
      check("busy_during_pulse", busy, 1);
      check("pulse_expected", rq.size() != 0, 1);
      if (rq.size() != 0) check("outcome_done", tx_done, rq.pop_front());
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] bytes [5] = '{8'hED, 8'h00, 8'h01, 8'hFF, 8'h80};
    logic par [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [10:0] f;
    logic early;
    int inh, n;
    n_chk = 0;
    n_pass = 0;
    after_pulse = 0;
    rst = 0;
    tx_valid = 0;
    tx_data = 0;
    dev_clk = 0;
    dev_dat = 0;
    glt = 0;
    repeat (3) @(negedge clk);
    check("reset_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    check("reset_pulses", {tx_done, tx_error}, 0);
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      send(bytes[i], 1, 1);
      dev_rx(1, 0, f);
      check("parity_bit", f[9], par[i]);
      wait_ready();
    end
    send(8'hA5, 1, 0);
    dev_rx(0, 0, f);
    wait_ready();
    send(8'h33, 0, 0);
    wait_req(inh, early);
    n = 0;
    while (!tx_error && n < 6000) begin @(negedge clk); n++; end
    check("timeout_cycles", n, TO);
    check("timeout_data_oe", ps2_data_oe, 0);
    wait_ready();
    send(8'h00, 0, -1);
    wait_req(inh, early);
    repeat (HP) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1;
      repeat (HP) @(negedge clk);
      dev_clk = 0;
      repeat (HP) @(negedge clk);
    end
    check("data_oe_before_reset", ps2_data_oe, 1);
    #3 rst = 0;
    #1;
    check("reset_mid_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    check("reset_mid_ready", tx_ready, 1);
    @(negedge clk);
    rst = 1;
    send(8'hFF, 1, 1);
    dev_rx(1, 0, f);
    wait_ready();
    send(8'hF4, 1, 1);
    tx_data = 8'h12;
    tx_valid = 1;
    fq.push_back(8'h12);
    rq.push_back(1'b1);
    dev_rx(1, 1, f);
    n = 0;
    while (!tx_ready && n < 500) begin @(negedge clk); n++; end
    check("held_valid_ready", tx_ready, 1);
    @(negedge clk);
    check("held_valid_accepted", busy, 1);
    tx_valid = 0;
    dev_rx(1, 0, f);
    wait_ready();
    repeat (5) @(negedge clk);
    check("frames_drained", fq.size(), 0);
    check("results_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
